// File: rtl/string_hw_pkg.sv
// Shared types for the string engine scheduler: op codes, string/length types, FSM states.
package string_hw_pkg;

    localparam int unsigned STR_BYTES = 2;

    typedef enum logic [2:0] {
        OP_STR_CMP  = 3'd0,
        OP_TO_UPPER = 3'd1
    } op_e;

    typedef logic [STR_BYTES-1:0][7:0] str_t;
    typedef logic [1:0] len_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RELEASE,
        RESP
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; grants only while enabled, pointer moves only on a grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // Set when requester 1 won most recently; reset value lets requester 0 win first.
    logic last_q;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (|gnt) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/string_hw_sched.sv
// Schedules commands from two requesters onto one string engine, one command in flight.
// Defining STRING_HW_SCHED_TIMEOUT_EN adds an ISSUE-state watchdog that ends the command with an error.
module string_hw_sched
    import string_hw_pkg::*;
#(
    parameter int unsigned NREQ           = 2,
    parameter int unsigned OP_COUNT       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][2:0]  req_index,
    input  str_t [NREQ-1:0]       req_a,
    input  str_t [NREQ-1:0]       req_b,
    input  len_t [NREQ-1:0]       req_len_a,
    input  len_t [NREQ-1:0]       req_len_b,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [15:0]           rsp_result,
    output logic                  rsp_err,
    output logic                  eng_go,
    output logic [2:0]            eng_index,
    output str_t                  eng_a,
    output str_t                  eng_b,
    output len_t                  eng_len_a,
    output len_t                  eng_len_b,
    input  logic                  eng_done,
    input  logic [15:0]           eng_result
);

    state_e      state_q;
    logic        owner_q;
    logic [15:0] result_q;
    logic [1:0]  gnt;
    logic        win;
    logic        bad_index;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_valid),
        .en    ((state_q == IDLE) && !reset),
        .gnt   (gnt)
    );

    assign req_ready = gnt;
    assign win       = gnt[1];
    assign bad_index = 32'(req_index[win]) >= OP_COUNT;

`ifdef STRING_HW_SCHED_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q;
    logic            timed_out_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            result_q   <= '0;
            eng_go     <= 1'b0;
            eng_index  <= '0;
            eng_a      <= '0;
            eng_b      <= '0;
            eng_len_a  <= '0;
            eng_len_b  <= '0;
            rsp_valid  <= '0;
            rsp_err    <= 1'b0;
            rsp_result <= '0;
`ifdef STRING_HW_SCHED_TIMEOUT_EN
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
`endif
        end else begin
            rsp_valid  <= '0;
            rsp_err    <= 1'b0;
            rsp_result <= '0;
            unique case (state_q)
                IDLE: begin
                    if (|gnt) begin
                        owner_q   <= win;
                        eng_index <= req_index[win];
                        eng_a     <= req_a[win];
                        eng_b     <= req_b[win];
                        eng_len_a <= req_len_a[win];
                        eng_len_b <= req_len_b[win];
                        if (bad_index) begin
                            // Unknown op never reaches the engine.
                            state_q   <= RESP;
                            rsp_valid <= gnt;
                            rsp_err   <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            eng_go  <= 1'b1;
`ifdef STRING_HW_SCHED_TIMEOUT_EN
                            cnt_q       <= '0;
                            timed_out_q <= 1'b0;
`endif
                        end
                    end
                end
                ISSUE: begin
                    if (eng_done) begin
                        result_q <= eng_result;
                        eng_go   <= 1'b0;
                        state_q  <= RELEASE;
                    end
`ifdef STRING_HW_SCHED_TIMEOUT_EN
                    else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                        result_q    <= '0;
                        timed_out_q <= 1'b1;
                        eng_go      <= 1'b0;
                        state_q     <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                RELEASE: begin
                    // Wait for the engine to drop done so it cannot be mistaken for the next one.
                    if (!eng_done) begin
                        state_q    <= RESP;
                        rsp_valid  <= owner_q ? 2'b10 : 2'b01;
                        rsp_result <= result_q;
`ifdef STRING_HW_SCHED_TIMEOUT_EN
                        rsp_err    <= timed_out_q;
`endif
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
